// File: rtl/exp_handler_mem.sv
// Writable exception-handler instruction store: loader write port with lock,
// per-word written flags, and a registered valid/ready read port.
module exp_handler_mem #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1c09_0000),
  parameter int unsigned       DEPTH     = 64,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_fault,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock,
  output logic              locked,
  output logic              wr_err
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(DEPTH * 4);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic [ADDR_W-1:0] rd_off, wr_off;
  logic              rd_in, wr_in;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              wr_ok, rd_accept, rd_hit_wr;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of window.
  always_comb begin
    rd_off    = rd_addr - BASE_ADDR;
    wr_off    = wr_addr - BASE_ADDR;
    rd_in     = (rd_off < WIN_BYTES) && (rd_addr[1:0] == 2'b00);
    wr_in     = (wr_off < WIN_BYTES) && (wr_addr[1:0] == 2'b00);
    rd_idx    = rd_off[IDX_W+1:2];
    wr_idx    = wr_off[IDX_W+1:2];
    wr_ok     = wr_en && !locked && wr_in;
    rd_accept = rd_req && (!rd_valid || rd_ready);
    rd_hit_wr = wr_ok && (wr_idx == rd_idx);
  end

  // Instruction array: no reset, validity comes from the written flags.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      locked  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      if (wr_ok) written[wr_idx] <= 1'b1;
      if (lock)  locked <= 1'b1;
      wr_err <= wr_en && !wr_ok;
    end
  end

  // Read output register; a same-cycle write to the read word is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_fault <= 1'b0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      if (!rd_in) begin
        rd_data  <= '0;
        rd_fault <= 1'b1;
      end else begin
        rd_fault <= 1'b0;
        if (rd_hit_wr)            rd_data <= wr_data;
        else if (written[rd_idx]) rd_data <= mem[rd_idx];
        else                      rd_data <= FILL_WORD;
      end
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exp_handler_mem.sv
// Scoreboard bench for exp_handler_mem: a reference model predicts each read
// result at its accept edge; results are compared when the consumer takes them.
module tb_exp_handler_mem;

  localparam logic [31:0] BASE = 32'h1c09_0000;
  localparam logic [31:0] FILL = 32'h0000_0013;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, rd_ready, rd_valid, rd_fault;
  logic [31:0] rd_addr, rd_data;
  logic        wr_en, lock, locked, wr_err;
  logic [31:0] wr_addr, wr_data;

  exp_handler_mem #(
    .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_fault(rd_fault),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock(lock), .locked(locked), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_flg;
  logic        m_valid, m_locked, m_wr_err;
  logic [32:0] sb_q [$];

  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'(DEPTH * 4)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flg    = '0;
      m_valid  = 1'b0;
      m_locked = 1'b0;
      m_wr_err = 1'b0;
      sb_q.delete();
    end else begin
      logic        w_ok, acc;
      logic [32:0] e;
      w_ok = wr_en && !m_locked && in_win(wr_addr);
      acc  = rd_req && (!m_valid || rd_ready);
      if (acc) begin
        if (!in_win(rd_addr))                            e = {1'b1, 32'h0};
        else if (w_ok && widx(wr_addr) == widx(rd_addr)) e = {1'b0, wr_data};
        else if (m_flg[widx(rd_addr)])                   e = {1'b0, m_mem[widx(rd_addr)]};
        else                                             e = {1'b0, FILL};
        sb_q.push_back(e);
        m_valid = 1'b1;
      end else if (rd_ready) begin
        m_valid = 1'b0;
      end
      if (w_ok) begin
        m_mem[widx(wr_addr)] = wr_data;
        m_flg[widx(wr_addr)] = 1'b1;
      end
      m_wr_err = wr_en && !w_ok;
      if (lock) m_locked = 1'b1;
    end
  end

  // Monitor on the falling edge: status every cycle, data when consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      check("wr_err", 64'(wr_err), 64'(m_wr_err));
      check("locked", 64'(locked), 64'(m_locked));
      if (m_valid && rd_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(e[31:0]));
          check("rd_fault", 64'(rd_fault), 64'(e[32]));
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    rd_req = 1'b0; wr_en = 1'b0; lock = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    rd_req = 1'b1; rd_addr = a;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    rst_n = 1'b0; rd_ready = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    idle();
    cyc(2);
    check("rst_valid", 64'(rd_valid), 64'(0));
    check("rst_data", 64'(rd_data), 64'(0));
    check("rst_fault", 64'(rd_fault), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    check("rst_wr_err", 64'(wr_err), 64'(0));
    rst_n = 1'b1;
    cyc();

    // Unwritten word returns the fill word
    rd(BASE + 32'h10); cyc(); idle(); cyc(2);

    // Two writes then back-to-back reads
    wr(32'h1c09_0000, 32'hff81_0113); cyc();
    wr(32'h1c09_0088, 32'h1020_0073); cyc(); idle();
    rd(32'h1c09_0000); cyc();
    rd(32'h1c09_0088); cyc(); idle(); cyc(2);

    // Faulting reads: below base, past end, misaligned
    rd(32'h1c08_fffc); cyc();
    rd(32'h1c09_0100); cyc();
    rd(32'h1c09_0002); cyc(); idle(); cyc(2);

    // Hold: consumer stalls while addresses change
    rd_ready = 1'b0;
    rd(32'h1c09_0000); cyc();
    rd(32'h1c09_0088); cyc();
    rd(32'h1c09_0100); cyc();
    rd(32'h1c09_0010); cyc();
    rd_ready = 1'b1;
    rd(32'h1c09_0088); cyc(); idle(); cyc(2);

    // Rejected out-of-window write while unlocked
    wr(32'h1c09_0200, 32'h1111_1111); cyc(); idle(); cyc();

    // Write coinciding with lock's first cycle is accepted, later one rejected
    wr(32'h1c09_0004, 32'h1234_5678); lock = 1'b1; cyc(); idle();
    check("locked_set", 64'(locked), 64'(1));
    wr(32'h1c09_0004, 32'hdead_beef); cyc();
    wr(32'h1c09_0008, 32'h2222_2222); cyc(); idle(); cyc();
    rd(32'h1c09_0004); cyc(); idle(); cyc(2);

    // Reset with a result pending; lock cleared, contents read as fill
    rd_ready = 1'b0; rd(32'h1c09_0004); cyc(); idle();
    rst_n = 1'b0; #1;
    check("arst_valid", 64'(rd_valid), 64'(0));
    check("arst_locked", 64'(locked), 64'(0));
    cyc(); rst_n = 1'b1; rd_ready = 1'b1; cyc();
    rd(32'h1c09_0004); cyc(); idle(); cyc(2);

    // Same-cycle write and read of one word
    wr(32'h1c09_000c, 32'h00a0_0293); rd(32'h1c09_000c); cyc(); idle(); cyc(2);

    // Random mix of reads, writes and stalls around the window edges
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, wa;
      ra = BASE - 32'h8 + 32'($urandom_range(0, 75)) * 4 + ($urandom_range(0, 7) == 0 ? 32'h2 : 32'h0);
      wa = BASE - 32'h8 + 32'($urandom_range(0, 75)) * 4 + ($urandom_range(0, 7) == 0 ? 32'h1 : 32'h0);
      rd_req = 1'($urandom_range(0, 1)); rd_addr = ra;
      rd_ready = ($urandom_range(0, 3) != 0);
      wr_en = 1'($urandom_range(0, 1)); wr_addr = wa; wr_data = $urandom;
      lock = (i == 350);
      cyc();
    end
    idle(); rd_ready = 1'b1; cyc(3);
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
